// File: rtl/llr_window_scheduler.sv
// Sequences one decoding window of symbols through the max-product LLR datapath, with credit-limited issue and an in-order output FIFO.
// Optional build macro LLR_SCHED_REVERSE_EN: windows run backward (addresses and indices n-1..0).
module llr_window_scheduler #(
  parameter int BITS            = 16,
  parameter int BITS_PER_SYMBOL = 2,
  parameter int SYMBOLS         = 10,
  parameter int FIFO_DEPTH      = 4,
  localparam int IDX_W = $clog2(SYMBOLS + 1),
  localparam int VEC_W = BITS * BITS_PER_SYMBOL,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] num_symbols,
  output logic             busy,
  output logic             done,
  output logic             mem_rd_en,
  output logic [IDX_W-1:0] mem_rd_addr,
  output logic             dp_in_valid,
  input  logic             dp_out_valid,
  input  logic [VEC_W-1:0] dp_llr,
  output logic             llr_valid,
  input  logic             llr_ready,
  output logic [VEC_W-1:0] llr_data,
  output logic [IDX_W-1:0] llr_index,
  output logic             err_overflow,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_credits
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Encoding is visible on dbg_state; 0 means idle.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] n_q, n_start, issued, popped;
  logic [CNT_W-1:0] credits, count;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [VEC_W-1:0] mem [FIFO_DEPTH];
  logic             issue, pop, push, full, push_ok, overflow;

  // Output port handshake: a vector transfers on every cycle where llr_valid && llr_ready;
  // llr_valid never drops and llr_data/llr_index never change until that transfer.
  assign llr_valid = (count != '0);
  assign pop       = llr_valid && llr_ready;
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign push      = dp_out_valid && (state != S_IDLE);
  assign push_ok   = push && (!full || pop);
  assign overflow  = push && full && !pop;
  assign n_start   = (num_symbols > IDX_W'(SYMBOLS)) ? IDX_W'(SYMBOLS) : num_symbols;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = (n_start == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        issue = (credits != '0) && (issued < n_q);
        if (issued == n_q) state_nxt = S_DRAIN;
      end
      // Looking at the pop in flight lets done follow the last pop by one cycle.
      S_DRAIN: if ((popped + IDX_W'(pop)) == n_q) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      n_q          <= '0;
      issued       <= '0;
      popped       <= '0;
      credits      <= CNT_W'(FIFO_DEPTH);
      dp_in_valid  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state       <= state_nxt;
      dp_in_valid <= issue;
      if (state == S_IDLE && start) begin
        n_q    <= n_start;
        issued <= '0;
        popped <= '0;
      end else begin
        if (issue) issued <= issued + IDX_W'(1);
        if (pop)   popped <= popped + IDX_W'(1);
      end
      if (issue && !pop)
        credits <= credits - CNT_W'(1);
      else if (!issue && pop && credits != CNT_W'(FIFO_DEPTH))
        credits <= credits + CNT_W'(1);
      if (overflow) err_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (push_ok && !pop)
        count <= count + CNT_W'(1);
      else if (!push_ok && pop)
        count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= dp_llr;
  end

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign mem_rd_en   = issue;
  assign llr_data    = llr_valid ? mem[rd_ptr] : '0;
  assign dbg_state   = state;
  assign dbg_credits = credits;

`ifdef LLR_SCHED_REVERSE_EN
  assign mem_rd_addr = issue ? (n_q - IDX_W'(1) - issued) : '0;
  assign llr_index   = llr_valid ? (n_q - IDX_W'(1) - popped) : '0;
`else
  assign mem_rd_addr = issue ? issued : '0;
  assign llr_index   = llr_valid ? popped : '0;
`endif

endmodule
